bus_slave_adapter: RTL and testbench

Responder end of the VTX1 bus matrix master protocol. It accepts single transactions from the matrix (req/wr/size/addr/wdata) and decodes them against one address window. Hits are forwarded to a simple peripheral handshake (req/ack/err), and the block returns ready, rdata or error/timeout with a code. One instance sits between a bus matrix slave port and each memory or register peripheral.

---
 rtl/bus_slave_adapter.sv | 172 +++++++++++++++++
 tb/tb_bus_slave_adapter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_adapter.sv
// VTX1 bus responder: single-window decode, peripheral req/ack/err handshake, timeout and error reporting.
// Define VTX1_SLAVE_WRITE_PROTECT_EN to add the wp_enable input and write-protect error code 5.
`ifndef VTX1_ADDR_WIDTH
`define VTX1_ADDR_WIDTH 32
`endif
`ifndef VTX1_WORD_WIDTH
`define VTX1_WORD_WIDTH 32
`endif

module bus_slave_adapter #(
    parameter logic [`VTX1_ADDR_WIDTH-1:0] BASE_ADDR = {`VTX1_ADDR_WIDTH{1'b0}},
    parameter int WINDOW_BITS    = 12,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef VTX1_SLAVE_WRITE_PROTECT_EN
    input  logic                          wp_enable,
`endif
    input  logic                          bus_req,
    input  logic                          bus_wr,
    input  logic [1:0]                    bus_size,
    input  logic [`VTX1_ADDR_WIDTH-1:0]   bus_addr,
    input  logic [`VTX1_WORD_WIDTH-1:0]   bus_wdata,
    output logic [`VTX1_WORD_WIDTH-1:0]   bus_rdata,
    output logic                          bus_ready,
    output logic                          bus_error,
    output logic [3:0]                    bus_error_code,
    output logic                          bus_timeout,
    input  logic                          bus_error_clear,
    output logic                          per_req,
    output logic                          per_wr,
    output logic [1:0]                    per_size,
    output logic [WINDOW_BITS-1:0]        per_addr,
    output logic [`VTX1_WORD_WIDTH-1:0]   per_wdata,
    input  logic [`VTX1_WORD_WIDTH-1:0]   per_rdata,
    input  logic                          per_ack,
    input  logic                          per_err,
    output logic [2:0]                    slave_state,
    output logic [31:0]                   access_count,
    output logic [31:0]                   error_count
);
    localparam int AW = `VTX1_ADDR_WIDTH;
    localparam int DW = `VTX1_WORD_WIDTH;
    localparam logic [3:0] TMO_LAST    = 4'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] CODE_NONE   = 4'd0;
    localparam logic [3:0] CODE_DECODE = 4'd1;
    localparam logic [3:0] CODE_SIZE   = 4'd2;
    localparam logic [3:0] CODE_PERIPH = 4'd3;
    localparam logic [3:0] CODE_TMO    = 4'd4;
    localparam logic [3:0] CODE_WP     = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_RESPOND = 3'd2,
        ST_ERROR   = 3'd3
    } state_t;

    state_t     state_r;
    logic [3:0] tmo_cnt_r;
    logic       size_bad_s;
    logic       win_hit_s;
    logic       wp_block_s;
    logic [3:0] idle_code_s;

    assign slave_state = state_r;

    // Request qualification: size first, then window decode, then write protection
    always_comb begin
        size_bad_s = (bus_size == 2'b11);
        win_hit_s  = (bus_addr[AW-1:WINDOW_BITS] == BASE_ADDR[AW-1:WINDOW_BITS]);
`ifdef VTX1_SLAVE_WRITE_PROTECT_EN
        wp_block_s = bus_wr & wp_enable;
`else
        wp_block_s = 1'b0;
`endif
        if (size_bad_s) begin
            idle_code_s = CODE_SIZE;
        end else if (!win_hit_s) begin
            idle_code_s = CODE_DECODE;
        end else if (wp_block_s) begin
            idle_code_s = CODE_WP;
        end else begin
            idle_code_s = CODE_NONE;
        end
    end

    // Transaction FSM with registered bus and peripheral outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            tmo_cnt_r      <= 4'd0;
            bus_rdata      <= {DW{1'b0}};
            bus_ready      <= 1'b0;
            bus_error      <= 1'b0;
            bus_error_code <= CODE_NONE;
            bus_timeout    <= 1'b0;
            per_req        <= 1'b0;
            per_wr         <= 1'b0;
            per_size       <= 2'b00;
            per_addr       <= {WINDOW_BITS{1'b0}};
            per_wdata      <= {DW{1'b0}};
            access_count   <= 32'd0;
            error_count    <= 32'd0;
        end else begin
            bus_ready <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus_req) begin
                        per_wr    <= bus_wr;
                        per_size  <= bus_size;
                        per_addr  <= bus_addr[WINDOW_BITS-1:0];
                        per_wdata <= bus_wdata;
                        if (idle_code_s != CODE_NONE) begin
                            state_r        <= ST_ERROR;
                            bus_error      <= 1'b1;
                            bus_error_code <= idle_code_s;
                            error_count    <= error_count + 32'd1;
                        end else begin
                            state_r   <= ST_ACCESS;
                            per_req   <= 1'b1;
                            tmo_cnt_r <= 4'd0;
                        end
                    end
                end
                ST_ACCESS: begin
                    // A fault reported alongside ack still wins over success
                    if (per_err) begin
                        state_r        <= ST_ERROR;
                        per_req        <= 1'b0;
                        bus_error      <= 1'b1;
                        bus_error_code <= CODE_PERIPH;
                        error_count    <= error_count + 32'd1;
                    end else if (per_ack) begin
                        state_r      <= ST_RESPOND;
                        per_req      <= 1'b0;
                        bus_ready    <= 1'b1;
                        access_count <= access_count + 32'd1;
                        if (!per_wr) begin
                            bus_rdata <= per_rdata;
                        end
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        state_r        <= ST_ERROR;
                        per_req        <= 1'b0;
                        bus_error      <= 1'b1;
                        bus_error_code <= CODE_TMO;
                        bus_timeout    <= 1'b1;
                        error_count    <= error_count + 32'd1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 4'd1;
                    end
                end
                ST_RESPOND: begin
                    state_r <= ST_IDLE;
                end
                ST_ERROR: begin
                    if (bus_error_clear) begin
                        state_r        <= ST_IDLE;
                        bus_error      <= 1'b0;
                        bus_error_code <= CODE_NONE;
                        bus_timeout    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    per_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_slave_adapter.sv
// Directed bench for bus_slave_adapter: a transaction-level model predicts every output each cycle,
// plus literal expectations that pin the model (write-protect cases run when VTX1_SLAVE_WRITE_PROTECT_EN is defined).
module tb_bus_slave_adapter;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int TMO = 8;
`ifdef VTX1_SLAVE_WRITE_PROTECT_EN
    localparam bit WP_BUILD = 1'b1;
`else
    localparam bit WP_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wp_enable = 1'b0;
    logic        bus_req = 1'b0;
    logic        bus_wr = 1'b0;
    logic [1:0]  bus_size = 2'b00;
    logic [31:0] bus_addr = 32'h0;
    logic [31:0] bus_wdata = 32'h0;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_error;
    logic [3:0]  bus_error_code;
    logic        bus_timeout;
    logic        bus_error_clear = 1'b0;
    logic        per_req;
    logic        per_wr;
    logic [1:0]  per_size;
    logic [11:0] per_addr;
    logic [31:0] per_wdata;
    logic [31:0] per_rdata = 32'h0;
    logic        per_ack = 1'b0;
    logic        per_err = 1'b0;
    logic [2:0]  slave_state;
    logic [31:0] access_count;
    logic [31:0] error_count;

    bus_slave_adapter #(.BASE_ADDR(BASE), .WINDOW_BITS(12), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef VTX1_SLAVE_WRITE_PROTECT_EN
        .wp_enable(wp_enable),
`endif
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_error(bus_error),
        .bus_error_code(bus_error_code), .bus_timeout(bus_timeout), .bus_error_clear(bus_error_clear),
        .per_req(per_req), .per_wr(per_wr), .per_size(per_size), .per_addr(per_addr),
        .per_wdata(per_wdata), .per_rdata(per_rdata), .per_ack(per_ack), .per_err(per_err),
        .slave_state(slave_state), .access_count(access_count), .error_count(error_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit drop_req = 1'b0;

    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_acc = 32'h0;
    logic [31:0] m_errc = 32'h0;
    logic [2:0]  e_state = 3'd0;
    logic        e_preq = 1'b0, e_ready = 1'b0, e_error = 1'b0, e_tmo = 1'b0, e_chk_per = 1'b0;
    logic [3:0]  e_code = 4'd0;
    logic        e_wr = 1'b0;
    logic [1:0]  e_size = 2'b00;
    logic [11:0] e_addr = 12'h0;
    logic [31:0] e_wdata = 32'h0;

    int          preq_len = 0;
    int          ready_pulses = 0;
    logic        prev_preq = 1'b0;
    logic [11:0] obs_addr = 12'h0;
    logic        obs_wr = 1'b0;
    logic [31:0] obs_wdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model expectations
    always @(negedge clk) begin
        if (chk_en) begin
            chk("slave_state", 32'(slave_state), 32'(e_state));
            chk("per_req", 32'(per_req), 32'(e_preq));
            chk("bus_ready", 32'(bus_ready), 32'(e_ready));
            chk("bus_error", 32'(bus_error), 32'(e_error));
            chk("bus_error_code", 32'(bus_error_code), 32'(e_code));
            chk("bus_timeout", 32'(bus_timeout), 32'(e_tmo));
            chk("bus_rdata", bus_rdata, m_rdata);
            chk("access_count", access_count, m_acc);
            chk("error_count", error_count, m_errc);
            if (e_chk_per) begin
                chk("per_wr", 32'(per_wr), 32'(e_wr));
                chk("per_size", 32'(per_size), 32'(e_size));
                chk("per_addr", 32'(per_addr), 32'(e_addr));
                chk("per_wdata", per_wdata, e_wdata);
            end
        end
    end

    // Observation of per_req bursts and ready pulses for the literal checks
    always @(negedge clk) begin
        if (per_req) begin
            if (!prev_preq) begin
                preq_len  <= 1;
                obs_addr  <= per_addr;
                obs_wr    <= per_wr;
                obs_wdata <= per_wdata;
            end else begin
                preq_len <= preq_len + 1;
            end
        end
        if (bus_ready) ready_pulses <= ready_pulses + 1;
        prev_preq <= per_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_state = 3'd0; e_preq = 1'b0; e_ready = 1'b0; e_error = 1'b0;
        e_code = 4'd0; e_tmo = 1'b0; e_chk_per = 1'b0;
    endtask

    // ack_at/err_at: ACCESS cycle (1-based) in which the peripheral responds, 0 = never
    task automatic run_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_at, input int err_at,
                           input logic [31:0] rdata, input int hold, input bit keep_req);
        int code;
        int n;
        code = 0;
        n = 0;
        if (size == 2'b11) code = 2;
        else if (addr[31:12] != BASE[31:12]) code = 1;
        else if (WP_BUILD && wp_enable && wr) code = 5;
        if (code == 0) begin
            if (err_at >= 1 && err_at <= TMO && (ack_at < 1 || err_at <= ack_at)) begin
                code = 3; n = err_at;
            end else if (ack_at >= 1 && ack_at <= TMO) begin
                n = ack_at;
            end else begin
                code = 4; n = TMO;
            end
        end
        set_idle();
        bus_req = 1'b1; bus_wr = wr; bus_size = size; bus_addr = addr; bus_wdata = wdata;
        tick();
        for (int j = 1; j <= n; j++) begin
            e_state = 3'd1; e_preq = 1'b1; e_ready = 1'b0; e_error = 1'b0; e_code = 4'd0; e_tmo = 1'b0;
            e_chk_per = 1'b1; e_wr = wr; e_size = size; e_addr = addr[11:0]; e_wdata = wdata;
            bus_req = drop_req ? 1'b0 : 1'b1;
            bus_addr = ~addr; bus_wdata = ~wdata; bus_wr = ~wr; bus_size = 2'b11;
            per_ack = (j == ack_at);
            per_err = (j == err_at);
            per_rdata = (j == ack_at) ? rdata : (32'hBAD0_0000 | 32'(j));
            tick();
        end
        per_ack = 1'b0; per_err = 1'b0;
        e_chk_per = 1'b0; e_preq = 1'b0;
        if (code == 0) begin
            m_acc = m_acc + 32'd1;
            if (!wr) m_rdata = rdata;
            e_state = 3'd2; e_ready = 1'b1;
            bus_req = 1'b0;
            tick();
        end else begin
            m_errc = m_errc + 32'd1;
            for (int k = 1; k <= hold; k++) begin
                e_state = 3'd3; e_ready = 1'b0; e_error = 1'b1; e_code = 4'(code); e_tmo = (code == 4);
                bus_req = (k == hold) ? keep_req : 1'b1;
                bus_error_clear = (k == hold);
                tick();
            end
            bus_error_clear = 1'b0;
        end
        set_idle();
        if (!keep_req) bus_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        #12;
        chk("rst_state", 32'(slave_state), 32'd0);
        chk("rst_per_req", 32'(per_req), 32'd0);
        chk("rst_bus_ready", 32'(bus_ready), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_bus_rdata", bus_rdata, 32'd0);
        chk("rst_access_count", access_count, 32'd0);
        chk("rst_error_count", error_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_idle();
        chk_en = 1'b1;

        r0 = ready_pulses;
        run_txn(1'b0, 2'b10, 32'h0000_1004, 32'h0, 2, 0, 32'hDEADBEEF, 0, 1'b0);
        chk("t1_per_addr", 32'(obs_addr), 32'h004);
        chk("t1_per_wr", 32'(obs_wr), 32'd0);
        chk("t1_preq_len", 32'(preq_len), 32'd2);
        chk("t1_ready_pulses", 32'(ready_pulses - r0), 32'd1);
        chk("t1_rdata", bus_rdata, 32'hDEADBEEF);
        chk("t1_access_count", access_count, 32'd1);

        run_txn(1'b1, 2'b10, 32'h0000_1FFC, 32'h12345678, 1, 0, 32'h0, 0, 1'b0);
        chk("t2_per_wr", 32'(obs_wr), 32'd1);
        chk("t2_per_wdata", obs_wdata, 32'h12345678);
        chk("t2_preq_len", 32'(preq_len), 32'd1);
        chk("t2_rdata_kept", bus_rdata, 32'hDEADBEEF);
        chk("t2_access_count", access_count, 32'd2);

        run_txn(1'b0, 2'b10, 32'h0000_2000, 32'h0, 1, 0, 32'h0, 3, 1'b0);
        run_txn(1'b0, 2'b11, 32'h0000_1000, 32'h0, 1, 0, 32'h0, 2, 1'b1);
        chk("t3_error_count", error_count, 32'd2);
        run_txn(1'b0, 2'b10, 32'h0000_1008, 32'h0, 1, 0, 32'hCAFEF00D, 0, 1'b0);
        chk("t3_rdata_after_clear", bus_rdata, 32'hCAFEF00D);

        run_txn(1'b0, 2'b10, 32'h0000_1020, 32'h0, 0, 0, 32'h0, 2, 1'b0);
        chk("t4_timeout_len", 32'(preq_len), 32'd8);
        chk("t4_error_count", error_count, 32'd3);
        r0 = ready_pulses;
        run_txn(1'b0, 2'b10, 32'h0000_1024, 32'h0, 8, 0, 32'h0BAD_CAFE, 0, 1'b0);
        chk("t4_ack_last_len", 32'(preq_len), 32'd8);
        chk("t4_ack_last_ready", 32'(ready_pulses - r0), 32'd1);

        r0 = ready_pulses;
        run_txn(1'b1, 2'b10, 32'h0000_1028, 32'h55AA55AA, 1, 1, 32'h0, 2, 1'b0);
        chk("t5_no_ready", 32'(ready_pulses - r0), 32'd0);
        chk("t5_error_count", error_count, 32'd4);
        run_txn(1'b0, 2'b10, 32'h0000_102C, 32'h0, 0, 3, 32'h0, 1, 1'b0);

        drop_req = 1'b1;
        run_txn(1'b0, 2'b10, 32'h0000_1030, 32'h0, 3, 0, 32'h13579BDF, 0, 1'b0);
        drop_req = 1'b0;
        run_txn(1'b1, 2'b00, 32'h0000_1001, 32'hA5A5A5A5, 2, 0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 2'b01, 32'h0000_1002, 32'h0, 1, 0, 32'h2468ACE0, 0, 1'b0);
        chk("t6_rdata", bus_rdata, 32'h2468ACE0);

`ifdef VTX1_SLAVE_WRITE_PROTECT_EN
        wp_enable = 1'b1;
        r0 = ready_pulses;
        run_txn(1'b1, 2'b10, 32'h0000_1010, 32'h11112222, 1, 0, 32'h0, 2, 1'b0);
        chk("wp_write_no_ready", 32'(ready_pulses - r0), 32'd0);
        run_txn(1'b0, 2'b10, 32'h0000_1010, 32'h0, 1, 0, 32'h77778888, 0, 1'b0);
        chk("wp_read_rdata", bus_rdata, 32'h77778888);
        run_txn(1'b1, 2'b11, 32'h0000_1010, 32'h0, 1, 0, 32'h0, 1, 1'b0);
        run_txn(1'b1, 2'b10, 32'h0000_3010, 32'h0, 1, 0, 32'h0, 1, 1'b0);
        wp_enable = 1'b0;
`endif

        chk_en = 1'b0;
        bus_req = 1'b1; bus_wr = 1'b0; bus_size = 2'b10; bus_addr = 32'h0000_1008;
        tick();
        bus_req = 1'b0;
        chk("rst_mid_pre_per_req", 32'(per_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_per_req", 32'(per_req), 32'd0);
        chk("rst_mid_state", 32'(slave_state), 32'd0);
        chk("rst_mid_rdata", bus_rdata, 32'd0);
        chk("rst_mid_access_count", access_count, 32'd0);
        chk("rst_mid_error_count", error_count, 32'd0);
        chk("rst_mid_per_addr", 32'(per_addr), 32'd0);
        m_rdata = 32'h0; m_acc = 32'h0; m_errc = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_idle();
        chk_en = 1'b1;
        run_txn(1'b0, 2'b10, 32'h0000_1040, 32'h0, 1, 0, 32'h5555AAAA, 0, 1'b0);
        chk("post_rst_access_count", access_count, 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
